// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: FSM states, the request record and item helpers.
package change_dispenser_pkg;

    localparam int PKG_ITEM_W   = 3;
    localparam int PKG_CHANGE_W = 5;
    localparam int REFUND_BIT   = 0;

    typedef enum logic [2:0] {
        IDLE,
        ITEM,
        COIN,
        GAP,
        DONE,
        FAULT
    } state_t;

    typedef struct packed {
        logic [PKG_ITEM_W-1:0]   item;
        logic [PKG_CHANGE_W-1:0] change;
    } request_t;

    // The refund code shares the item one-hot but has no motor behind it.
    function automatic logic [PKG_ITEM_W-1:0] physical_item(input logic [PKG_ITEM_W-1:0] item);
        logic [PKG_ITEM_W-1:0] motor;
        motor             = item;
        motor[REFUND_BIT] = 1'b0;
        return motor;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Per-bit rising-edge detector: one flop of history per bit, pulse while the level is newly high.
module rise_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] level_q;

    // NOTE: flops are written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/change_dispenser.sv
// Drives the item motor and coin hopper for one vend result at a time, with a 1-deep pending slot.
// Optional handshake timeout and FAULT state: define DISPENSER_TIMEOUT_EN.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int NUM_CHOICES_SIZE = PKG_ITEM_W,
    parameter int CHANGE_W         = PKG_CHANGE_W,
    parameter int GAP_CYCLES       = 4,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [CHANGE_W-1:0]         i_change,
    input  logic [NUM_CHOICES_SIZE-1:0] i_item,
    input  logic                        i_item_done,
    input  logic                        i_coin_done,
    input  logic                        i_fault_clr,
    output logic [NUM_CHOICES_SIZE-1:0] o_motor,
    output logic                        o_coin_req,
    output logic [CHANGE_W-1:0]         o_coins_left,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overrun,
    output logic                        o_fault
);

    localparam int                  GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CHANGE_W-1:0] ONE_COIN = CHANGE_W'(1);

    state_t                        state;
    request_t                      active;
    request_t                      pend;
    logic                          pend_valid;
    logic [GAP_W-1:0]              gap_cnt;

    request_t                      in_req;
    logic                          in_valid;
    request_t                      launch_req;
    logic [NUM_CHOICES_SIZE-1:0]   launch_motor;
    logic                          item_rise;
    logic                          coin_rise;

`ifdef DISPENSER_TIMEOUT_EN
    localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            fault_q;

    assign o_fault = fault_q;
`else
    logic unused_cfg;

    // NOTE: without the timeout build o_fault is a constant, not a flop; the clear input has no effect.
    assign o_fault    = 1'b0;
    assign unused_cfg = i_fault_clr ^ (TIMEOUT_CYCLES != 0);
`endif

    rise_edge_det #(.WIDTH(1)) u_item_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_item_done),
        .o_rise  (item_rise)
    );

    rise_edge_det #(.WIDTH(1)) u_coin_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_coin_done),
        .o_rise  (coin_rise)
    );

    assign in_req.item   = i_item;
    assign in_req.change = i_change;
    assign in_valid      = (i_item != '0) || (i_change != '0);

    // A waiting request always launches ahead of one arriving in the same cycle.
    always_comb begin
        launch_req = in_req;
        if (pend_valid) begin
            launch_req = pend;
        end
    end

    assign launch_motor = physical_item(launch_req.item);
    assign o_coins_left = active.change;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            active     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            gap_cnt    <= '0;
            o_motor    <= '0;
            o_coin_req <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overrun  <= 1'b0;
`ifdef DISPENSER_TIMEOUT_EN
            to_cnt     <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;

            // IDLE frees the pending slot by launching it, so a same-cycle request refills it.
            if (state == IDLE) begin
                if (pend_valid) begin
                    pend       <= in_req;
                    pend_valid <= in_valid;
                end
            end else if (in_valid) begin
                if (!pend_valid) begin
                    pend       <= in_req;
                    pend_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end

`ifdef DISPENSER_TIMEOUT_EN
            to_cnt <= '0;
`endif

            case (state)
                IDLE: begin
                    if (pend_valid || in_valid) begin
                        active <= launch_req;
                        o_busy <= 1'b1;
                        if (launch_motor != '0) begin
                            state   <= ITEM;
                            o_motor <= launch_motor;
                        end else if (launch_req.change != '0) begin
                            state      <= COIN;
                            o_coin_req <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                ITEM: begin
                    if (item_rise) begin
                        o_motor <= '0;
                        if (active.change != '0) begin
                            state      <= COIN;
                            o_coin_req <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
`ifdef DISPENSER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state   <= FAULT;
                        o_motor <= '0;
                        fault_q <= 1'b1;
                    end
`endif
                    else begin
                        o_motor <= physical_item(active.item);
`ifdef DISPENSER_TIMEOUT_EN
                        to_cnt  <= to_cnt + 1'b1;
`endif
                    end
                end

                COIN: begin
                    if (coin_rise) begin
                        o_coin_req    <= 1'b0;
                        active.change <= (active.change != '0) ? active.change - 1'b1 : '0;
                        if (active.change != ONE_COIN) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
`ifdef DISPENSER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state      <= FAULT;
                        o_coin_req <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= COIN;
                        o_coin_req <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

`ifdef DISPENSER_TIMEOUT_EN
                FAULT: begin
                    o_motor    <= '0;
                    o_coin_req <= 1'b0;
                    if (i_fault_clr) begin
                        state   <= IDLE;
                        fault_q <= 1'b0;
                        o_busy  <= 1'b0;
                        active  <= '0;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; outputs are sampled 1 time unit after each rising edge.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] change = '0;
    logic [2:0] item = '0;
    logic       item_done = 1'b0;
    logic       coin_done = 1'b0;
    logic       fault_clr = 1'b0;

    logic [2:0] motor;
    logic       coin_req;
    logic [4:0] coins_left;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .NUM_CHOICES_SIZE (3),
        .CHANGE_W         (5),
        .GAP_CYCLES       (4),
        .TIMEOUT_CYCLES   (10)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_change     (change),
        .i_item       (item),
        .i_item_done  (item_done),
        .i_coin_done  (coin_done),
        .i_fault_clr  (fault_clr),
        .o_motor      (motor),
        .o_coin_req   (coin_req),
        .o_coins_left (coins_left),
        .o_busy       (busy),
        .o_done       (done),
        .o_overrun    (overrun),
        .o_fault      (fault)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_motor, input logic e_coin,
                              input logic [4:0] e_left, input logic e_busy, input logic e_done);
        check({tag, ".motor"}, 32'(motor), 32'(e_motor));
        check({tag, ".coin_req"}, 32'(coin_req), 32'(e_coin));
        check({tag, ".coins_left"}, 32'(coins_left), 32'(e_left));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    // One-cycle request, as the upstream FSM produces it.
    task automatic send(input logic [2:0] it, input logic [4:0] ch);
        item   = it;
        change = ch;
        tick();
        item   = '0;
        change = '0;
    endtask

    task automatic coin_ack();
        coin_done = 1'b1;
        tick();
        coin_done = 1'b0;
    endtask

    task automatic item_ack();
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_outs("rst", 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        tick();

        // Item 2 with two quarters
        send(3'b010, 5'd2);
        check_outs("A.launch", 3'b010, 1'b0, 5'd2, 1'b1, 1'b0);
        tick(3);
        check("A.motor_held", 32'(motor), 32'b010);
        item_ack();
        check_outs("A.item_ack", 3'b000, 1'b1, 5'd2, 1'b1, 1'b0);
        tick(2);
        check("A.coin_held", 32'(coin_req), 32'd1);
        coin_ack();
        check_outs("A.coin1", 3'b000, 1'b0, 5'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("A.gap_low", 32'(coin_req), 32'd0);
        end
        tick();
        check("A.gap_end", 32'(coin_req), 32'd1);
        coin_ack();
        check_outs("A.coin2", 3'b000, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("A.done", 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check("A.done_pulse", 32'(done), 32'd0);

        // Refund with five quarters: motor never runs
        send(3'b001, 5'd5);
        check_outs("B.launch", 3'b000, 1'b1, 5'd5, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("B.coin_req", 32'(coin_req), 32'd1);
            check("B.motor", 32'(motor), 32'd0);
            coin_ack();
            check("B.left", 32'(coins_left), 32'(4 - k));
            check("B.coin_drop", 32'(coin_req), 32'd0);
            if (k < 4) tick(4);
        end
        check_outs("B.last", 3'b000, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("B.done", 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();

        // Refund with zero change: o_done two cycles after the request
        send(3'b001, 5'd0);
        check_outs("B0.launch", 3'b000, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("B0.done", 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();

        // Buffering, overrun and sensor noise
        send(3'b001, 5'd3);
        check_outs("C.launch", 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
        send(3'b100, 5'd0);
        check("C.pend_overrun", 32'(overrun), 32'd0);
        check("C.pend_coin", 32'(coin_req), 32'd1);
        send(3'b010, 5'd1);
        check("C.overrun", 32'(overrun), 32'd1);
        item_ack();
        check_outs("C.item_noise", 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
        coin_done = 1'b1;
        tick();
        check("C.held_ack_left", 32'(coins_left), 32'd2);
        tick(4);
        check("C.held_coin_req", 32'(coin_req), 32'd1);
        tick(2);
        check("C.held_no_count", 32'(coins_left), 32'd2);
        check("C.held_still_req", 32'(coin_req), 32'd1);
        coin_done = 1'b0;
        tick();
        coin_ack();
        check("C.fresh_ack_left", 32'(coins_left), 32'd1);
        tick(4);
        coin_ack();
        check_outs("C.last_coin", 3'b000, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("C.done", 3'b000, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check_outs("C.pend_launch", 3'b100, 1'b0, 5'd0, 1'b1, 1'b0);
        check("C.overrun_sticky", 32'(overrun), 32'd1);
        item_ack();
        check_outs("C.pend_item_ack", 3'b000, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check("C.pend_done", 32'(done), 32'd1);
        tick();

        // Asynchronous reset in the middle of a coin handshake
        send(3'b000, 5'd3);
        check_outs("D.pre", 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("D.reset", 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        check("D.reset_overrun", 32'(overrun), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check_outs("D.idle", 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        send(3'b010, 5'd1);
        check_outs("D.launch", 3'b010, 1'b0, 5'd1, 1'b1, 1'b0);
        item_ack();
        check_outs("D.item_ack", 3'b000, 1'b1, 5'd1, 1'b1, 1'b0);
        coin_ack();
        check("D.left", 32'(coins_left), 32'd0);
        tick();
        check("D.done", 32'(done), 32'd1);
        tick();

`ifdef DISPENSER_TIMEOUT_EN
        // Missing coin ack: fault after ten cycles of request
        send(3'b000, 5'd1);
        tick(9);
        check("E.before_fault", 32'(fault), 32'd0);
        check("E.req_cycle10", 32'(coin_req), 32'd1);
        tick();
        check("E.fault", 32'(fault), 32'd1);
        check("E.req_forced", 32'(coin_req), 32'd0);
        check("E.busy", 32'(busy), 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_outs("E.cleared", 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        check("E.fault_clr", 32'(fault), 32'd0);
`else
        // Missing coin ack: the handshake waits indefinitely
        send(3'b000, 5'd1);
        tick(2000);
        check("E.req_held", 32'(coin_req), 32'd1);
        check("E.busy", 32'(busy), 32'd1);
        check("E.no_fault", 32'(fault), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("E.clr_ignored", 32'(coin_req), 32'd1);
        coin_ack();
        tick();
        check("E.done", 32'(done), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
